// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the buffered 1-to-2 stream demultiplexer.
//   CH0 / CH1     : values of the per-word select bit naming each output channel
//   fifo_state_e  : occupancy state of a 2-entry channel FIFO; the encoding
//                   equals the number of stored words (0, 1, 2)
// ----------------------------------------------------------------------------
package demux_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

endpackage : demux_pkg

// File: rtl/demux_fifo2.sv
// ----------------------------------------------------------------------------
// demux_fifo2
// Two-entry FIFO used as the per-channel buffer of the demultiplexer.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset (empties the FIFO, clears data)
//   push       in   write push_data this cycle (ignored while full)
//   push_data  in   WIDTH word to store
//   full       out  two words stored
//   pop        in   remove the head word this cycle (ignored while empty)
//   empty      out  no word stored
//   head_data  out  oldest stored word; holds its value until popped
// Storage is two registers plus a head pointer. Push writes the slot after
// the head (or the head slot itself when empty); pop only flips the pointer,
// so data registers change solely on a push.
// ----------------------------------------------------------------------------
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    fifo_state_e      state_q, state_d;
    logic             head_q, head_d;
    logic [WIDTH-1:0] mem_q [2];

    logic             do_push;
    logic             do_pop;
    logic             tail;

    assign full    = (state_q == FULL);
    assign empty   = (state_q == EMPTY);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Free slot: the head slot when empty, the other slot when one word is held.
    assign tail      = head_q ^ (state_q == ONE);
    assign head_data = mem_q[head_q];

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        if (do_pop) begin
            head_d = ~head_q;
        end
        case (state_q)
            EMPTY: begin
                if (do_push) state_d = ONE;
            end
            ONE: begin
                // push+pop keeps one word: the new word becomes the head
                if (do_push && !do_pop)      state_d = FULL;
                else if (do_pop && !do_push) state_d = EMPTY;
            end
            FULL: begin
                if (do_pop) state_d = ONE;
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            head_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            if (do_push) begin
                mem_q[tail] <= push_data;
            end
        end
    end

endmodule : demux_fifo2

// File: rtl/demux1to2_buf.sv
// ----------------------------------------------------------------------------
// demux1to2_buf
// Buffered 1-to-2 stream demultiplexer. Each input word is steered by its
// select bit into one of two 2-entry channel FIFOs, so a stalled consumer
// never blocks the other channel.
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   in_data/in_sel         input word and destination (0 -> out0, 1 -> out1)
//   in_valid/in_ready      input handshake
//   outN_data/outN_valid   head word of channel N FIFO / FIFO non-empty
//   outN_ready             consumer takes the head word of channel N
//   cnt0/cnt1              words popped per channel since reset (wrapping)
// Handshake: a word transfers on a rising edge where valid and ready are both
// high. in_ready depends only on in_sel and registered FIFO state (never on
// outN_ready); outN_data is stable while outN_valid is high and outN_ready low.
// ----------------------------------------------------------------------------
module demux1to2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             full0, full1;
    logic             empty0, empty1;
    logic             accept;
    logic             push0, push1;
    logic             pop0, pop1;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Ready reflects only the addressed channel, so a full channel stalls
    // just the words destined for it.
    assign in_ready = (in_sel == CH1) ? ~full1 : ~full0;
    assign accept   = in_valid & in_ready;
    assign push0    = accept & (in_sel == CH0);
    assign push1    = accept & (in_sel == CH1);

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;
    assign pop0       = out0_valid & out0_ready;
    assign pop1       = out1_valid & out1_ready;

    demux_fifo2 #(
        .WIDTH(WIDTH)
    ) u_fifo0 (
        .clk      (clk),
        .rst      (rst),
        .push     (push0),
        .push_data(in_data),
        .full     (full0),
        .pop      (pop0),
        .empty    (empty0),
        .head_data(out0_data)
    );

    demux_fifo2 #(
        .WIDTH(WIDTH)
    ) u_fifo1 (
        .clk      (clk),
        .rst      (rst),
        .push     (push1),
        .push_data(in_data),
        .full     (full1),
        .pop      (pop1),
        .empty    (empty1),
        .head_data(out1_data)
    );

    // Pop counters wrap naturally at 2^CNT_W.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (pop0) cnt0_d = cnt0_q + CNT_W'(1);
        if (pop1) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

endmodule : demux1to2_buf

// File: tb/tb_demux1to2_buf.sv
module tb_demux1to2_buf;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CNT_MASK = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [CNT_W-1:0] cnt0, cnt1;

  demux1to2_buf #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- scoreboard / model ----------------
  // Each channel is a queue of words in arrival order, capacity two.
  logic [WIDTH-1:0] exp0_q[$];
  logic [WIDTH-1:0] exp1_q[$];
  int pops0 = 0;
  int pops1 = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_out0_valid", 32'(out0_valid), 32'd0);
      check("rst_out1_valid", 32'(out1_valid), 32'd0);
      check("rst_out0_data", 32'(out0_data), 32'd0);
      check("rst_out1_data", 32'(out1_data), 32'd0);
      check("rst_cnt0", 32'(cnt0), 32'd0);
      check("rst_cnt1", 32'(cnt1), 32'd0);
      exp0_q.delete();
      exp1_q.delete();
      pops0 = 0;
      pops1 = 0;
    end else begin
      bit room;
      bit take0, take1;
      room = in_sel ? (exp1_q.size() < 2) : (exp0_q.size() < 2);
      check("out0_valid", 32'(out0_valid), 32'(exp0_q.size() != 0));
      check("out1_valid", 32'(out1_valid), 32'(exp1_q.size() != 0));
      if (exp0_q.size() != 0) check("out0_data", 32'(out0_data), 32'(exp0_q[0]));
      if (exp1_q.size() != 0) check("out1_data", 32'(out1_data), 32'(exp1_q[0]));
      check("in_ready", 32'(in_ready), 32'(room));
      check("cnt0", 32'(cnt0), 32'(pops0 & CNT_MASK));
      check("cnt1", 32'(cnt1), 32'(pops1 & CNT_MASK));
      // Advance the model by what the coming edge will transfer.
      take0 = (exp0_q.size() != 0) && out0_ready;
      take1 = (exp1_q.size() != 0) && out1_ready;
      if (take0) begin void'(exp0_q.pop_front()); pops0++; end
      if (take1) begin void'(exp1_q.pop_front()); pops1++; end
      if (in_valid && room) begin
        if (in_sel) exp1_q.push_back(in_data);
        else        exp0_q.push_back(in_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic [WIDTH-1:0] d, input logic s,
                        input logic r0, input logic r1);
    in_valid   = v;
    in_data    = d;
    in_sel     = s;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s,
                       input logic r0, input logic r1);
    set_in(v, d, s, r0, r1);
    tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b1;
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out0_valid", 32'(out0_valid), 32'd0);
    check("post_rst_cnt1", 32'(cnt1), 32'd0);

    // Steering with both consumers ready
    drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    check("steer_out0_first", 32'(out0_data), 32'h11);
    check("steer_out0_valid", 32'(out0_valid), 32'd1);
    drive(1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
    check("steer_out1_word", 32'(out1_data), 32'h22);
    check("steer_out0_drained", 32'(out0_valid), 32'd0);
    drive(1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    check("steer_out0_second", 32'(out0_data), 32'h33);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("steer_cnt0", 32'(cnt0), 32'd2);
    check("steer_cnt1", 32'(cnt1), 32'd1);

    // Back-pressure on channel 0
    drive(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1);
    set_in(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1);
    #1 check("bp_stall_ready", 32'(in_ready), 32'd0);
    tick();
    check("bp_head_held", 32'(out0_data), 32'hA0);
    set_in(1'b1, 8'hB0, 1'b1, 1'b0, 1'b1);
    #1 check("bp_other_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_other_word", 32'(out1_data), 32'hB0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("bp_second_head", 32'(out0_data), 32'hA1);
    drive(1'b1, 8'hA2, 1'b0, 1'b1, 1'b1);
    check("bp_third_head", 32'(out0_data), 32'hA2);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("bp_cnt0", 32'(cnt0), 32'd5);
    check("bp_cnt1", 32'(cnt1), 32'd2);

    // Simultaneous push and pop at one word on channel 1
    drive(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    set_in(1'b1, 8'h66, 1'b1, 1'b1, 1'b1);
    #1 check("pp_ready", 32'(in_ready), 32'd1);
    tick();
    check("pp_new_head", 32'(out1_data), 32'h66);
    check("pp_still_valid", 32'(out1_valid), 32'd1);
    check("pp_cnt1", 32'(cnt1), 32'd3);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Push to one channel while the other pops
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h88, 1'b1, 1'b1, 1'b0);
    check("indep_out0_empty", 32'(out0_valid), 32'd0);
    check("indep_out1_word", 32'(out1_data), 32'h88);
    check("indep_cnt0", 32'(cnt0), 32'd6);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Fill both channels, then reset asynchronously mid-cycle
    drive(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hD0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out0_valid", 32'(out0_valid), 32'd0);
    check("async_rst_out1_valid", 32'(out1_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_cnt1", 32'(cnt1), 32'd0);
    tick();
    rst = 1'b0;

    // 17 pops on channel 0 at full rate: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("wrap_cnt0", 32'(cnt0), 32'd1);
    check("wrap_cnt1", 32'(cnt1), 32'd0);

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    repeat (4) tick();
    check("drain_out0_valid", 32'(out0_valid), 32'd0);
    check("drain_out1_valid", 32'(out1_valid), 32'd0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_demux1to2_buf

// File: doc/demux1to2_buf.md
# demux1to2_buf

Buffered 1-to-2 stream demultiplexer: the inverse of the 2:1 mux. A single valid/ready input stream is steered, word by word, to one of two output streams according to a per-word select bit. Each output owns a 2-entry FIFO so a stalled channel does not block the other. Per-channel transfer counters support debug and bench checking. It sits where a shared datapath fans back out to two consumers.

## Interface
- WIDTH, 8, data width of input and both outputs
- CNT_W, 16, width of per-channel transfer counters
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  input word
- in_sel  in  1  destination: 0 → out0, 1 → out1; sampled with in_data
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the word this cycle
- out0_data / out1_data  out  WIDTH  head word of channel FIFO
- out0_valid / out1_valid  out  1  channel FIFO non-empty
- out0_ready / out1_ready  in  1  consumer takes head word
- cnt0 / cnt1  out  CNT_W  words popped from channel 0 / 1 since reset

## Operation
- Accept: in_valid & in_ready at a clk edge pushes in_data into FIFO[in_sel].
- in_ready = ~full[in_sel]; depends only on in_sel and registered FIFO state, never on outN_ready (no combinational ready-to-ready path).
- in_ready may be high while in_valid is low; in_sel is don't-care when in_valid=0.
- Pop: outN_valid & outN_ready at an edge removes the head word of channel N and increments cntN.
- Each FIFO: count 0..2, states EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push+pop → ONE, new word becomes head.
  - FULL: pop → ONE; push impossible (in_ready=0 for this channel).
- outN_valid = (countN != 0); outN_data = head word; outN_data holds its value while valid & ~ready.
- Ordering: per channel strictly FIFO; no ordering guarantee across channels.
- Counters: wrap from 2^CNT_W−1 to 0, no saturation.
- Channels independent: push to one and pop from the other in the same cycle both take effect.

## Timing
- Latency: word accepted at edge k is visible on outN_data with outN_valid=1 after edge k (cycle k+1) when the FIFO was empty.
- Throughput: one word/cycle per channel sustained when consumer holds ready=1.
- Reset (rst=1, asynchronous): out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0, FIFO counts 0. in_ready reads 1 immediately after reset.
- Reset mid-operation: all buffered words discarded, no partial pop counted; first edge after rst deasserts behaves as from empty.
- Data registers not written when no push occurs; head-pointer advance only on pop.

## Structure
- Shared package demux_pkg: localparam CH0=1'b0, CH1=1'b1; FIFO state encoding (EMPTY/ONE/FULL) as a 2-bit typedef.
- Sub-module demux_fifo2 (WIDTH parameter; clk, rst, push, push_data, full, pop, empty, head_data), instantiated twice; top holds steering logic and counters.
- Target 150–250 lines RTL total.

## Test plan
- Reset: hold rst, release → all outputs 0, in_ready=1; assert rst asynchronously mid-cycle with both FIFOs FULL → valids drop to 0 before next edge.
- Steering: push 0x11(sel 0), 0x22(sel 1), 0x33(sel 0) with both readies 1 → out0 sees 0x11, 0x33; out1 sees 0x22; each one cycle after accept; cnt0=2, cnt1=1.
- Back-pressure: out0_ready=0, push 0xA0, 0xA1, 0xA2 to ch0 → third word stalls (in_ready=0 while in_sel=0); switching in_sel=1 with 0xB0 → in_ready=1 and accepted; release out0_ready → 0xA0, 0xA1, 0xA2 in order.
- Simultaneous push/pop at count 1: ch1 holds 0x55, push 0x66 while out1_ready=1 → 0x55 popped, 0x66 next cycle, count stays 1.
- Counter wrap: CNT_W=4, pop 17 words on ch0 → cnt0=1.
- Random soak: random in_valid/in_sel/outN_ready for 10k cycles → scoreboard per-channel order exact, no loss/duplication, cntN equals scoreboard pops mod 2^CNT_W.
